// File: rtl/uart_rx.sv
// uart_rx: memory-mapped 8N1 UART receiver (LSB first) for the peripheral bus.
// The line is oversampled at 16x baud by a phase-accumulator tick. Received
// bytes and status flags are exposed through DATA_ADDR and STAT_ADDR.
// Optional build macro UART_RX_FIFO_EN replaces the single holding register
// with a 4-entry receive FIFO and reports its fill level in status bits [5:3].
module uart_rx #(
   parameter int unsigned ACC_W     = 28,
   parameter int unsigned TICK_INC  = 858992,
   parameter logic [3:0]  DATA_ADDR = 4'h6,
   parameter logic [3:0]  STAT_ADDR = 4'h7
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        en,
   input  logic [2:0]  write_enable,
   input  logic [23:0] addr,
   input  logic [31:0] data_in,
   output logic [31:0] data_out,
   input  logic        uart_rxd,
   output logic        uart_rx_valid,
   output logic        uart_rx_err
);

   // Receiver states
   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_START   = 3'd1;
   localparam logic [2:0] ST_DATA    = 3'd2;
   localparam logic [2:0] ST_STOP    = 3'd3;
   localparam logic [2:0] ST_WAIT_HI = 3'd4;

   // Accumulator increment, sized one bit wider so the carry is visible
   localparam logic [ACC_W:0] TICK_STEP = (ACC_W + 1)'(TICK_INC);

   // ------------------------------------------------------------------
   // Oversample tick generator
   // ------------------------------------------------------------------
   logic [ACC_W-1:0] acc_reg;
   logic [ACC_W:0]   acc_sum;
   logic             tick;

   assign acc_sum = {1'b0, acc_reg} + TICK_STEP;
   assign tick    = acc_sum[ACC_W];

   // Advance the phase accumulator every clock; the carry is the 16x tick
   always_ff @(posedge clk) begin
      if (!resetn) begin
         acc_reg <= '0;
      end else begin
         acc_reg <= acc_sum[ACC_W-1:0];
      end
   end

   // ------------------------------------------------------------------
   // Input synchronizer (line idles high, so the flops reset to 1)
   // ------------------------------------------------------------------
   logic rxd_meta_reg;
   logic rxs_reg;

   // Two-flop synchronizer for the asynchronous serial input
   always_ff @(posedge clk) begin
      if (!resetn) begin
         rxd_meta_reg <= 1'b1;
         rxs_reg      <= 1'b1;
      end else begin
         rxd_meta_reg <= uart_rxd;
         rxs_reg      <= rxd_meta_reg;
      end
   end

   // ------------------------------------------------------------------
   // Bus decode
   // ------------------------------------------------------------------
   logic bus_rd;
   logic rd_data_sel;
   logic rd_stat_sel;
   logic wr_stat;
   logic unused_bus_bits;

   assign bus_rd      = en && (write_enable == 3'b000);
   assign rd_data_sel = bus_rd && (addr[3:0] == DATA_ADDR);
   assign rd_stat_sel = bus_rd && (addr[3:0] == STAT_ADDR);
   assign wr_stat     = en && write_enable[0] && (addr[3:0] == STAT_ADDR);

   // Only addr[3:0] and the two flag-clear bits of the write data are decoded
   assign unused_bus_bits = ^{addr[23:4], data_in[31:3], data_in[0]};

   // ------------------------------------------------------------------
   // Frame state machine
   // ------------------------------------------------------------------
   logic [2:0] state_reg, state_next;
   logic [3:0] tcnt_reg, tcnt_next;
   logic [2:0] bidx_reg, bidx_next;
   logic [7:0] shift_reg, shift_next;
   logic       sample_bit;
   logic       deliver;
   logic       frame_set;

   // Next-state logic; nothing moves except on tick cycles
   always_comb begin
      state_next = state_reg;
      tcnt_next  = tcnt_reg;
      bidx_next  = bidx_reg;
      sample_bit = 1'b0;
      deliver    = 1'b0;
      frame_set  = 1'b0;
      if (tick) begin
         case (state_reg)
            ST_IDLE: begin
               if (!rxs_reg) begin
                  state_next = ST_START;
                  tcnt_next  = 4'd0;
               end
            end
            ST_START: begin
               tcnt_next = tcnt_reg + 4'd1;
               // Middle of the start bit: a high line means it was a glitch
               if (tcnt_reg == 4'd7) begin
                  tcnt_next = 4'd0;
                  if (!rxs_reg) begin
                     state_next = ST_DATA;
                     bidx_next  = 3'd0;
                  end else begin
                     state_next = ST_IDLE;
                  end
               end
            end
            ST_DATA: begin
               // 4-bit counter wraps 15 -> 0 so each bit is 16 ticks apart
               tcnt_next = tcnt_reg + 4'd1;
               if (tcnt_reg == 4'd15) begin
                  sample_bit = 1'b1;
                  if (bidx_reg == 3'd7) begin
                     state_next = ST_STOP;
                     tcnt_next  = 4'd0;
                  end else begin
                     bidx_next = bidx_reg + 3'd1;
                  end
               end
            end
            ST_STOP: begin
               tcnt_next = tcnt_reg + 4'd1;
               if (tcnt_reg == 4'd15) begin
                  tcnt_next = 4'd0;
                  if (rxs_reg) begin
                     deliver    = 1'b1;
                     state_next = ST_IDLE;
                  end else begin
                     // Bad stop bit: flag once, then wait out any break
                     frame_set  = 1'b1;
                     state_next = ST_WAIT_HI;
                  end
               end
            end
            ST_WAIT_HI: begin
               if (rxs_reg) begin
                  state_next = ST_IDLE;
               end
            end
            default: begin
               state_next = ST_IDLE;
            end
         endcase
      end
   end

   // Per-bit capture of the data shift register, LSB first
   for (genvar gi = 0; gi < 8; gi++) begin : g_shift
      assign shift_next[gi] = (sample_bit && (bidx_reg == 3'(gi))) ? rxs_reg
                                                                   : shift_reg[gi];
   end

   // Frame state registers
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_reg <= ST_IDLE;
         tcnt_reg  <= 4'd0;
         bidx_reg  <= 3'd0;
         shift_reg <= 8'h00;
      end else begin
         state_reg <= state_next;
         tcnt_reg  <= tcnt_next;
         bidx_reg  <= bidx_next;
         shift_reg <= shift_next;
      end
   end

   // ------------------------------------------------------------------
   // Received-byte storage
   // ------------------------------------------------------------------
   logic       rx_valid;
   logic [7:0] head_byte;
   logic [2:0] stat_count;
   logic       ovr_set;

`ifdef UART_RX_FIFO_EN
   logic [7:0] fifo_mem [4];
   logic [1:0] wr_ptr_reg;
   logic [1:0] rd_ptr_reg;
   logic [2:0] count_reg;
   logic       pop;
   logic       push;

   // A pop frees a slot in the same cycle, so a full FIFO still accepts
   assign pop        = rd_data_sel && (count_reg != 3'd0);
   assign push       = deliver && ((count_reg != 3'd4) || pop);
   assign ovr_set    = deliver && !push;
   assign rx_valid   = (count_reg != 3'd0);
   assign head_byte  = pop ? fifo_mem[rd_ptr_reg] : 8'h00;
   assign stat_count = count_reg;

   // FIFO storage array (no reset; contents are qualified by count)
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_mem[wr_ptr_reg] <= shift_reg;
      end
   end

   // FIFO pointers and fill level
   always_ff @(posedge clk) begin
      if (!resetn) begin
         wr_ptr_reg <= 2'd0;
         rd_ptr_reg <= 2'd0;
         count_reg  <= 3'd0;
      end else begin
         if (push) begin
            wr_ptr_reg <= wr_ptr_reg + 2'd1;
         end
         if (pop) begin
            rd_ptr_reg <= rd_ptr_reg + 2'd1;
         end
         case ({push, pop})
            2'b10:   count_reg <= count_reg + 3'd1;
            2'b01:   count_reg <= count_reg - 3'd1;
            default: count_reg <= count_reg;
         endcase
      end
   end
`else
   logic [7:0] rx_data_reg;
   logic       rx_valid_reg;

   // A data read in the delivery cycle frees the register for the new byte
   assign ovr_set    = deliver && rx_valid_reg && !rd_data_sel;
   assign rx_valid   = rx_valid_reg;
   assign head_byte  = rx_data_reg;
   assign stat_count = 3'd0;

   // Single holding register: load on delivery, clear valid on data read
   always_ff @(posedge clk) begin
      if (!resetn) begin
         rx_data_reg  <= 8'h00;
         rx_valid_reg <= 1'b0;
      end else if (deliver && (!rx_valid_reg || rd_data_sel)) begin
         rx_data_reg  <= shift_reg;
         rx_valid_reg <= 1'b1;
      end else if (rd_data_sel) begin
         rx_valid_reg <= 1'b0;
      end
   end
`endif

   // ------------------------------------------------------------------
   // Status flags
   // ------------------------------------------------------------------
   logic overrun_reg;
   logic frame_err_reg;

   // Sticky error flags; a set in the same cycle as a clear wins
   always_ff @(posedge clk) begin
      if (!resetn) begin
         overrun_reg   <= 1'b0;
         frame_err_reg <= 1'b0;
      end else begin
         if (ovr_set) begin
            overrun_reg <= 1'b1;
         end else if (wr_stat && data_in[1]) begin
            overrun_reg <= 1'b0;
         end
         if (frame_set) begin
            frame_err_reg <= 1'b1;
         end else if (wr_stat && data_in[2]) begin
            frame_err_reg <= 1'b0;
         end
      end
   end

   // ------------------------------------------------------------------
   // Registered read data
   // ------------------------------------------------------------------

   // Read mux; data_out holds its value between reads
   always_ff @(posedge clk) begin
      if (!resetn) begin
         data_out <= 32'h0;
      end else if (bus_rd) begin
         if (rd_data_sel) begin
            data_out <= {24'h0, head_byte};
         end else if (rd_stat_sel) begin
            data_out <= {26'h0, stat_count, frame_err_reg, overrun_reg, rx_valid};
         end else begin
            data_out <= 32'h0;
         end
      end
   end

   assign uart_rx_valid = rx_valid;
   assign uart_rx_err   = overrun_reg | frame_err_reg;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed bench for uart_rx with a queue-based reference model.
// Bit period is 64 clk (ACC_W=4, TICK_INC=4). Define UART_RX_FIFO_EN to
// exercise the FIFO build.
module tb_uart_rx;

   localparam logic [3:0] DATA_A = 4'h6;
   localparam logic [3:0] STAT_A = 4'h7;
`ifdef UART_RX_FIFO_EN
   localparam int DEPTH = 4;
   localparam bit FIFO  = 1'b1;
`else
   localparam int DEPTH = 1;
   localparam bit FIFO  = 1'b0;
`endif
   localparam logic [31:0] STAT_ONE = FIFO ? 32'h9 : 32'h1;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        en = 1'b0;
   logic [2:0]  write_enable = 3'b000;
   logic [23:0] addr = 24'h0;
   logic [31:0] data_in = 32'h0;
   logic [31:0] data_out;
   logic        uart_rxd = 1'b1;
   logic        uart_rx_valid;
   logic        uart_rx_err;

   int total = 0;
   int bad = 0;

   // Reference model state
   int         ecount = 0;
   logic [7:0] mq [$];
   logic [7:0] m_last = 8'h00;
   logic       m_ovr = 1'b0;
   logic       m_ferr = 1'b0;
   logic [31:0] m_dout = 32'h0;
   int         pend_d [$];
   logic [7:0] pend_b [$];
   logic       pend_ok [$];

   uart_rx #(
      .ACC_W(4),
      .TICK_INC(4),
      .DATA_ADDR(DATA_A),
      .STAT_ADDR(STAT_A)
   ) dut (
      .clk(clk),
      .resetn(resetn),
      .en(en),
      .write_enable(write_enable),
      .addr(addr),
      .data_in(data_in),
      .data_out(data_out),
      .uart_rxd(uart_rxd),
      .uart_rx_valid(uart_rx_valid),
      .uart_rx_err(uart_rx_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %08h expected %08h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] model_status();
      logic [2:0] c;
      c = FIFO ? 3'(mq.size()) : 3'd0;
      return {26'h0, c, m_ferr, m_ovr, (mq.size() != 0)};
   endfunction

   // Model update at each edge, then compare DUT outputs on the falling edge
   initial begin
      logic rd, rd_data, rd_stat, wr_stat;
      forever begin
         @(posedge clk);
         if (!resetn) begin
            ecount = 0;
            mq.delete();
            m_last = 8'h00;
            m_ovr  = 1'b0;
            m_ferr = 1'b0;
            m_dout = 32'h0;
            pend_d.delete();
            pend_b.delete();
            pend_ok.delete();
         end else begin
            ecount++;
            rd      = en && (write_enable == 3'b000);
            rd_data = rd && (addr[3:0] == DATA_A);
            rd_stat = rd && (addr[3:0] == STAT_A);
            wr_stat = en && write_enable[0] && (addr[3:0] == STAT_A);
            if (rd_data)
               m_dout = (mq.size() != 0) ? {24'h0, mq[0]} : {24'h0, (FIFO ? 8'h00 : m_last)};
            else if (rd_stat)
               m_dout = model_status();
            else if (rd)
               m_dout = 32'h0;
            if (rd_data && mq.size() != 0) void'(mq.pop_front());
            if (wr_stat && data_in[1]) m_ovr = 1'b0;
            if (wr_stat && data_in[2]) m_ferr = 1'b0;
            if (pend_d.size() != 0 && pend_d[0] == ecount) begin
               if (pend_ok[0]) begin
                  if (mq.size() < DEPTH) begin
                     mq.push_back(pend_b[0]);
                     m_last = pend_b[0];
                  end else begin
                     m_ovr = 1'b1;
                  end
               end else begin
                  m_ferr = 1'b1;
               end
               void'(pend_d.pop_front());
               void'(pend_b.pop_front());
               void'(pend_ok.pop_front());
            end
         end
         @(negedge clk);
         chk("cyc_valid", {31'h0, uart_rx_valid}, {31'h0, (mq.size() != 0)});
         chk("cyc_err", {31'h0, uart_rx_err}, {31'h0, (m_ovr | m_ferr)});
         chk("cyc_data_out", data_out, m_dout);
      end
   end

   task automatic wait_clk(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Serial frame: start, 8 data bits LSB first, stop; line left at stop level
   task automatic send_frame(input logic [7:0] b, input logic stop, input bit expected);
      int s, k;
      @(posedge clk);
      #1;
      uart_rxd = 1'b0;
      s = ecount;
      if (expected) begin
         // first 16x tick that sees the synchronized low, then mid-stop sample
         k = ((s + 6) / 4) * 4;
         pend_d.push_back(k + 608);
         pend_b.push_back(b);
         pend_ok.push_back(stop);
      end
      $display("send frame byte=%02h stop=%0b", b, stop);
      wait_clk(64);
      for (int i = 0; i < 8; i++) begin
         uart_rxd = b[i];
         wait_clk(64);
      end
      uart_rxd = stop;
      wait_clk(64);
   endtask

   task automatic bus_read(input logic [3:0] a, input logic [31:0] exp, input string nm);
      en = 1'b1;
      write_enable = 3'b000;
      addr = {20'h0, a};
      wait_clk(1);
      en = 1'b0;
      $display("read addr=%h data=%08h", a, data_out);
      chk(nm, data_out, exp);
   endtask

   task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
      en = 1'b1;
      write_enable = 3'b001;
      addr = {20'h0, a};
      data_in = d;
      wait_clk(1);
      en = 1'b0;
      write_enable = 3'b000;
      $display("write addr=%h data=%08h", a, d);
   endtask

   initial begin
      // Reset
      wait_clk(3);
      resetn = 1'b1;
      chk("rst_data_out", data_out, 32'h0);
      chk("rst_valid", {31'h0, uart_rx_valid}, 32'h0);
      chk("rst_err", {31'h0, uart_rx_err}, 32'h0);
      wait_clk(20);

      // Single byte
      send_frame(8'hA5, 1'b1, 1'b1);
      uart_rxd = 1'b1;
      wait_clk(10);
      bus_read(DATA_A, 32'h0000_00A5, "data_a5");
      bus_read(STAT_A, 32'h0, "stat_after_a5");

      // Short low glitch on idle line
      uart_rxd = 1'b0;
      wait_clk(16);
      uart_rxd = 1'b1;
      wait_clk(100);
      bus_read(STAT_A, 32'h0, "stat_after_glitch");

      // Two bytes without an intervening read
      send_frame(8'h3C, 1'b1, 1'b1);
      uart_rxd = 1'b1;
      send_frame(8'h5A, 1'b1, 1'b1);
      uart_rxd = 1'b1;
      wait_clk(10);
`ifdef UART_RX_FIFO_EN
      bus_read(STAT_A, 32'h11, "stat_two_queued");
      bus_read(DATA_A, 32'h3C, "data_3c");
      bus_read(DATA_A, 32'h5A, "data_5a");
`else
      bus_read(STAT_A, 32'h3, "stat_overrun");
      bus_read(DATA_A, 32'h3C, "data_3c");
      bus_read(STAT_A, 32'h2, "stat_ovr_only");
`endif
      bus_write(STAT_A, 32'h2);
      bus_read(STAT_A, 32'h0, "stat_ovr_cleared");

      // Bad stop bit followed by a held-low break
      send_frame(8'h81, 1'b0, 1'b1);
      wait_clk(100);
      chk("ferr_set", {31'h0, uart_rx_err}, 32'h1);
      bus_read(STAT_A, 32'h4, "stat_frame_err");
      bus_write(STAT_A, 32'h4);
      bus_read(STAT_A, 32'h0, "stat_ferr_cleared");
      wait_clk(394);
      uart_rxd = 1'b1;
      wait_clk(100);
      send_frame(8'h42, 1'b1, 1'b1);
      uart_rxd = 1'b1;
      wait_clk(10);
      bus_read(STAT_A, STAT_ONE, "stat_42_valid");

      // Reset in the middle of the data bits of an abandoned frame
      @(posedge clk);
      #1;
      uart_rxd = 1'b0;
      wait_clk(256);
      resetn = 1'b0;
      uart_rxd = 1'b1;
      wait_clk(1);
      resetn = 1'b1;
      chk("midrst_data_out", data_out, 32'h0);
      chk("midrst_valid", {31'h0, uart_rx_valid}, 32'h0);
      wait_clk(50);
      send_frame(8'h0F, 1'b1, 1'b1);
      uart_rxd = 1'b1;
      wait_clk(10);
      bus_read(DATA_A, 32'h0F, "data_0f");
      bus_read(STAT_A, 32'h0, "stat_after_0f");

`ifdef UART_RX_FIFO_EN
      // Overfill the FIFO
      for (int i = 1; i <= 5; i++) begin
         send_frame(8'(i), 1'b1, 1'b1);
         uart_rxd = 1'b1;
      end
      wait_clk(10);
      bus_read(STAT_A, 32'h23, "stat_fifo_full");
      bus_read(DATA_A, 32'h01, "fifo_01");
      bus_read(DATA_A, 32'h02, "fifo_02");
      bus_read(DATA_A, 32'h03, "fifo_03");
      bus_read(DATA_A, 32'h04, "fifo_04");
      bus_read(DATA_A, 32'h00, "fifo_empty");
`endif

      wait_clk(5);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Guard against a stuck run
   initial begin
      #2ms;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
